popcount_frame_accumulator: RTL and testbench
=============================================

# popcount_frame_accumulator

Sequential stage that sits directly downstream of the per-word population counter. It consumes one Hamming-weight count per accepted beat over a valid/ready stream and sums the counts over a frame. A frame is delimited by `in_last` or closed automatically at `FRAME_LEN` beats. It then presents the frame total, the beat count and status flags on a valid/ready output port for the next stage.

## Interface

Parameters:
- `BITS`, default 4: width of the word counted upstream. Input count width is CW = $clog2(BITS)+1.
- `FRAME_LEN`, default 16: maximum beats per frame (≥1). Beat-count width is NW = $clog2(FRAME_LEN+1).
- `THRESH`, default 32: threshold for `out_over`. Total width is SW = $clog2(BITS*FRAME_LEN+1).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input, 1: single clock; all state changes on its rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: `in_count`/`in_last` valid.
- `in_ready` output, 1: block can accept a beat.
- `in_count` input, CW: per-word population count.
- `in_last` input, 1: beat is the final beat of the frame.
- `out_valid` output, 1: frame result available.
- `out_ready` input, 1: consumer accepts the result.
- `out_total` output, SW: sum of (clamped) counts in the frame.
- `out_words` output, NW: number of beats in the frame (1..FRAME_LEN).
- `out_over` output, 1: `out_total` ≥ THRESH.
- `out_trunc` output, 1: frame closed at FRAME_LEN beats without `in_last`.
- `out_clamp` output, 1: at least one beat had `in_count` > BITS.

## Operation

- Two-state FSM: ACCUM and HOLD. Reset state is ACCUM.
- `in_ready` = (state == ACCUM). Combinational from the state register only, never from `in_valid`.
- In ACCUM, an input handshake (`in_valid` & `in_ready`) does the following:
  - c = min(`in_count`, BITS); `acc` += c; `nbeat` += 1.
  - Clamp flag sets if `in_count` > BITS.
  - If `in_last`=1 or the new `nbeat` == FRAME_LEN: latch result registers (total, words, over, trunc = !`in_last`, clamp) and go to HOLD.
- In HOLD:
  - `out_valid`=1 and outputs are held stable.
  - On `out_ready`=1: clear `acc`, `nbeat` and the clamp flag, go to ACCUM.
- `in_valid` without `in_ready` is ignored; no state change.
- Arithmetic:
  - `acc` is SW bits and cannot overflow, since c ≤ BITS and beats ≤ FRAME_LEN.
  - `out_over` is computed from the final total, not a running value.
- When `in_last` and the FRAME_LEN limit coincide, `out_trunc`=0.
- Result registers are retained after acceptance until the next frame closes. Values are only meaningful while `out_valid`=1.

## Timing

- Reset (`rst_n` low, asynchronous):
  - State = ACCUM, `acc` = 0, `nbeat` = 0.
  - `out_valid`, `out_total`, `out_words`, `out_over`, `out_trunc`, `out_clamp` all = 0.
  - `in_ready` = 1 while in ACCUM after reset.
- Latency: `out_valid` rises on the clock edge that accepts the closing beat, i.e. it is visible in the next cycle.
- Output handshake: `out_valid` stays high until the cycle with `out_ready`=1. `in_ready` returns to 1 the cycle after that handshake.
- Throughput: one bubble per frame. A frame of N beats occupies at least N+1 cycles.
- `out_ready` high before `out_valid` has no effect.
- Reset mid-frame or in HOLD:
  - The partial frame or pending result is discarded.
  - No `out_valid` is produced for it.
  - The next accepted beat starts a new frame.

## Test plan

Bench parameters: BITS=4, FRAME_LEN=4, THRESH=10.

- Counts 1,2,3 with `in_last` on the 3rd beat, `out_ready`=1 -> one cycle later total=6, words=3, over=0, trunc=0, clamp=0; `in_ready` low for exactly 1 cycle.
- Counts 4,3,2,1 with no `in_last` -> auto-close: total=10, words=4, over=1, trunc=1. Same counts with `in_last` on the 4th beat -> trunc=0.
- Single beat, count 0 with `in_last` -> total=0, words=1, over=0.
- `in_count`=7 with `in_last` -> total=4, clamp=1. The next frame (count 1, last) -> total=1, clamp=0.
- `out_ready` held low 5 cycles after close while `in_valid`=1 -> outputs stable, `in_ready`=0, no beats consumed. Raising `out_ready` accepts the result, and the next frame's first beat is accepted one cycle later.
- Assert `rst_n` after 2 beats (counts 4,4), then send 1,1 with last -> total=2, words=2; no result emitted for the aborted frame.

Source files
------------

// File: rtl/popcount_frame_accumulator.sv
// Sums per-word Hamming-weight counts over a frame (closed by in_last or FRAME_LEN beats)
// and presents the total, beat count and status flags on a valid/ready result port.
module popcount_frame_accumulator #(
    parameter int BITS      = 4,
    parameter int FRAME_LEN = 16,
    parameter int THRESH    = 32,
    localparam int CW = $clog2(BITS) + 1,
    localparam int NW = $clog2(FRAME_LEN + 1),
    localparam int SW = $clog2(BITS * FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_count,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_total,
    output logic [NW-1:0] out_words,
    output logic          out_over,
    output logic          out_trunc,
    output logic          out_clamp
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state;
    logic [SW-1:0] acc;
    logic [NW-1:0] nbeat;
    logic          clamp_seen;

    logic          beat_clamp;
    logic [SW-1:0] beat_val;
    logic [SW-1:0] acc_next;
    logic [NW-1:0] nbeat_next;
    logic          frame_close;
    logic          over_next;

    assign in_ready = (state == ACCUM);

    // Counts above BITS are impossible from a healthy upstream; saturate and flag them.
    assign beat_clamp  = (in_count > CW'(BITS));
    assign beat_val    = beat_clamp ? SW'(BITS) : SW'(in_count);
    assign acc_next    = acc + beat_val;
    assign nbeat_next  = nbeat + NW'(1);
    assign frame_close = in_last || (nbeat_next == NW'(FRAME_LEN));
    assign over_next   = ($unsigned(32'(acc_next)) >= $unsigned(32'(THRESH)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            acc        <= '0;
            nbeat      <= '0;
            clamp_seen <= 1'b0;
            out_valid  <= 1'b0;
            out_total  <= '0;
            out_words  <= '0;
            out_over   <= 1'b0;
            out_trunc  <= 1'b0;
            out_clamp  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc        <= acc_next;
                        nbeat      <= nbeat_next;
                        clamp_seen <= clamp_seen | beat_clamp;
                        if (frame_close) begin
                            out_total <= acc_next;
                            out_words <= nbeat_next;
                            out_over  <= over_next;
                            out_trunc <= !in_last;
                            out_clamp <= clamp_seen | beat_clamp;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Result registers are left as-is; only the running frame state is cleared.
                    if (out_ready) begin
                        acc        <= '0;
                        nbeat      <= '0;
                        clamp_seen <= 1'b0;
                        out_valid  <= 1'b0;
                        state      <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Randomized and directed self-checking bench for popcount_frame_accumulator against a
// frame-level reference model (queue of beats, summed when the frame closes).
module tb_popcount_frame_accumulator;

    localparam int BITS      = 4;
    localparam int FRAME_LEN = 4;
    localparam int THRESH    = 10;
    localparam int CW = $clog2(BITS) + 1;
    localparam int NW = $clog2(FRAME_LEN + 1);
    localparam int SW = $clog2(BITS * FRAME_LEN + 1);
    localparam int RW = SW + NW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_count = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_total;
    logic [NW-1:0] out_words;
    logic          out_over;
    logic          out_trunc;
    logic          out_clamp;

    int assertCount = 0;
    int failCount   = 0;

    int frameQ[$];
    int expTotal, expWords, expOver, expTrunc, expClamp;

    popcount_frame_accumulator #(
        .BITS(BITS), .FRAME_LEN(FRAME_LEN), .THRESH(THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_total(out_total), .out_words(out_words), .out_over(out_over),
        .out_trunc(out_trunc), .out_clamp(out_clamp)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] observed();
        return {out_total, out_words, out_over, out_trunc, out_clamp};
    endfunction

    function automatic logic [RW-1:0] expected();
        return {SW'(expTotal), NW'(expWords), expOver[0], expTrunc[0], expClamp[0]};
    endfunction

    // Frame-level model: collect beats, and when the frame closes derive the result from them.
    function automatic void modelBeat(input int c, input bit last);
        int total;
        bit clamp;
        frameQ.push_back(c);
        if (last || frameQ.size() == FRAME_LEN) begin
            total = 0;
            clamp = 0;
            foreach (frameQ[i]) begin
                total += (frameQ[i] > BITS) ? BITS : frameQ[i];
                if (frameQ[i] > BITS) clamp = 1;
            end
            expTotal = total;
            expWords = frameQ.size();
            expOver  = (total >= THRESH) ? 1 : 0;
            expTrunc = last ? 0 : 1;
            expClamp = clamp ? 1 : 0;
            frameQ.delete();
        end
    endfunction

    task automatic applyStimulus(input int c, input bit last);
        int cycles = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_count = CW'(c);
        in_last  = last;
        while (in_ready !== 1'b1 && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        assertCount++;
        if (in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL beat_accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        modelBeat(c, last);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic waitResult(output bit got);
        int cycles = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        got = (out_valid === 1'b1);
    endtask

    task automatic acceptResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        assertCount++;
        if (observed() !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got %h required 0", observed());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        applyStimulus(3, 1);
        @(negedge clk);
        assertCount++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL basic_latency: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        assertCount++;
        if (observed() !== expected()) begin
            failCount++;
            $display("[TB] FAIL basic_result: got %h required %h", observed(), expected());
        end
        @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL basic_bubble: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_auto_close();
        bit got;
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(4, 0);
            applyStimulus(3, 0);
            applyStimulus(2, 0);
            applyStimulus(1, pass == 1);
            waitResult(got);
            assertCount++;
            if (!got || observed() !== expected()) begin
                failCount++;
                $display("[TB] FAIL auto_close_%0d: valid=%b got %h required %h", pass, got, observed(), expected());
            end
            acceptResult();
        end
    endtask

    task automatic test_zero_and_clamp();
        bit got;
        int counts[3] = '{0, 7, 1};
        foreach (counts[i]) begin
            applyStimulus(counts[i], 1);
            waitResult(got);
            assertCount++;
            if (!got || observed() !== expected()) begin
                failCount++;
                $display("[TB] FAIL single_beat_%0d: valid=%b got %h required %h", counts[i], got, observed(), expected());
            end
            acceptResult();
        end
    endtask

    task automatic test_back_pressure();
        bit got;
        logic [RW-1:0] held;
        applyStimulus(2, 0);
        applyStimulus(2, 1);
        waitResult(got);
        held = expected();
        in_valid = 1'b1;
        in_count = CW'(3);
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            assertCount++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== held) begin
                failCount++;
                $display("[TB] FAIL hold_stable_%0d: valid=%b ready=%b got %h required %h", i, out_valid, in_ready, observed(), held);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL hold_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        modelBeat(3, 1);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        assertCount++;
        if (out_valid !== 1'b1 || observed() !== expected()) begin
            failCount++;
            $display("[TB] FAIL hold_next_frame: valid=%b got %h required %h", out_valid, observed(), expected());
        end
        acceptResult();
    endtask

    task automatic test_reset_midframe();
        bit got;
        applyStimulus(4, 0);
        applyStimulus(4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        assertCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || observed() !== '0) begin
            failCount++;
            $display("[TB] FAIL midframe_reset: ready=%b valid=%b got %h required 1/0/0", in_ready, out_valid, observed());
        end
        frameQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        assertCount++;
        if (out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midframe_no_result: out_valid=%b required 0", out_valid);
        end
        applyStimulus(1, 0);
        applyStimulus(1, 1);
        waitResult(got);
        assertCount++;
        if (!got || observed() !== expected()) begin
            failCount++;
            $display("[TB] FAIL midframe_restart: valid=%b got %h required %h", got, observed(), expected());
        end
        acceptResult();
    endtask

    task automatic test_random();
        bit got;
        int delay;
        for (int f = 0; f < 40; f++) begin
            do begin
                applyStimulus($urandom_range(0, 7), $urandom_range(0, 3) == 0);
            end while (frameQ.size() != 0);
            waitResult(got);
            delay = $urandom_range(0, 3);
            for (int d = 0; d < delay; d++) @(negedge clk);
            assertCount++;
            if (!got || out_valid !== 1'b1 || observed() !== expected()) begin
                failCount++;
                $display("[TB] FAIL random_frame_%0d: valid=%b got %h required %h", f, out_valid, observed(), expected());
            end
            acceptResult();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_auto_close();
        test_zero_and_clamp();
        test_back_pressure();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
